operand_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU; produces its op/a/b operands.
- Holds the architectural register file and a per-register busy scoreboard.
- Accepts decoded instructions from decode, reads ra/rb (or substitutes an immediate for b), bypasses same-cycle writeback data, and presents a registered {op, a, b, rd} bundle to execute over a valid/ready handshake.
- Stalls decode on RAW/WAW hazards until the pending writeback lands.

---
 rtl/operand_stage.sv | 153 +++++++++++++++
 tb/tb_operand_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// ============================================================================
// Module      : operand_stage
// Description : Register file, busy scoreboard and operand fetch stage that
//               feeds the ALU over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_stage #(
   parameter int REG_BITS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter bit R0_ZERO    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [REG_BITS-1:0]   in_ra,
   input  logic [REG_BITS-1:0]   in_rb,
   input  logic [REG_BITS-1:0]   in_rd,
   input  logic                  in_writes_rd,
   input  logic                  in_use_imm,
   input  logic [DATA_WIDTH-1:0] in_imm,

   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            out_op,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic [REG_BITS-1:0]   out_rd,
   output logic                  out_writes_rd,

   input  logic                  wb_en,
   input  logic [REG_BITS-1:0]   wb_reg,
   input  logic [DATA_WIDTH-1:0] wb_data
);

   localparam int c_NUM_REGS = 2 ** REG_BITS;

   logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
   logic [c_NUM_REGS-1:0] r_busy;

   logic                  r_out_valid;
   logic [3:0]            r_out_op;
   logic [DATA_WIDTH-1:0] r_out_a;
   logic [DATA_WIDTH-1:0] r_out_b;
   logic [REG_BITS-1:0]   r_out_rd;
   logic                  r_out_writes_rd;

   logic                  w_ra_zero;
   logic                  w_rb_zero;
   logic                  w_rd_zero;
   logic                  w_wb_zero;
   logic                  w_ra_hit;
   logic                  w_rb_hit;
   logic                  w_rd_hit;
   logic [DATA_WIDTH-1:0] w_a_val;
   logic [DATA_WIDTH-1:0] w_rb_val;
   logic [DATA_WIDTH-1:0] w_b_val;
   logic                  w_ra_busy;
   logic                  w_rb_busy;
   logic                  w_rd_busy;
   logic                  w_hazard;
   logic                  w_in_xfer;
   logic                  w_out_xfer;
   logic                  w_set_busy;
   logic [c_NUM_REGS-1:0] w_busy_next;

   assign w_ra_zero = R0_ZERO && (in_ra  == '0);
   assign w_rb_zero = R0_ZERO && (in_rb  == '0);
   assign w_rd_zero = R0_ZERO && (in_rd  == '0);
   assign w_wb_zero = R0_ZERO && (wb_reg == '0);

   assign w_ra_hit = wb_en && (wb_reg == in_ra);
   assign w_rb_hit = wb_en && (wb_reg == in_rb);
   assign w_rd_hit = wb_en && (wb_reg == in_rd);

   // Writeback landing this cycle is forwarded so a consumer can issue with it.
   assign w_a_val  = w_ra_zero ? '0 : (w_ra_hit ? wb_data : r_regs[in_ra]);
   assign w_rb_val = w_rb_zero ? '0 : (w_rb_hit ? wb_data : r_regs[in_rb]);
   assign w_b_val  = in_use_imm ? in_imm : w_rb_val;

   assign w_ra_busy = r_busy[in_ra] && !w_ra_hit;
   assign w_rb_busy = !in_use_imm && r_busy[in_rb] && !w_rb_hit;
   assign w_rd_busy = in_writes_rd && r_busy[in_rd] && !w_rd_hit;
   assign w_hazard  = w_ra_busy || w_rb_busy || w_rd_busy;

   assign in_ready   = !rst && !w_hazard && (!r_out_valid || out_ready);
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_out_valid && out_ready;
   assign w_set_busy = w_in_xfer && in_writes_rd && !w_rd_zero;

   // Set is applied after clear so a new writer claiming the register wins.
   always_comb begin
      w_busy_next = r_busy;
      if (wb_en) begin
         w_busy_next[wb_reg] = 1'b0;
      end
      if (w_set_busy) begin
         w_busy_next[in_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_regs <= '{default: '0};
      end else if (wb_en && !w_wb_zero) begin
         r_regs[wb_reg] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid     <= 1'b0;
         r_out_op        <= '0;
         r_out_a         <= '0;
         r_out_b         <= '0;
         r_out_rd        <= '0;
         r_out_writes_rd <= 1'b0;
      end else begin
         if (w_in_xfer) begin
            r_out_valid     <= 1'b1;
            r_out_op        <= in_op;
            r_out_a         <= w_a_val;
            r_out_b         <= w_b_val;
            r_out_rd        <= in_rd;
            r_out_writes_rd <= in_writes_rd;
         end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid     = r_out_valid;
   assign out_op        = r_out_op;
   assign out_a         = r_out_a;
   assign out_b         = r_out_b;
   assign out_rd        = r_out_rd;
   assign out_writes_rd = r_out_writes_rd;

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// ============================================================================
// Module      : tb_operand_stage
// Description : Scoreboard bench for operand_stage (REG_BITS=4, 32-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_operand_stage;

   typedef logic [72:0] bundle_t;   // {op, a, b, rd, writes_rd}

   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [3:0]  in_ra;
   logic [3:0]  in_rb;
   logic [3:0]  in_rd;
   logic        in_writes_rd;
   logic        in_use_imm;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [3:0]  out_rd;
   logic        out_writes_rd;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [31:0] wb_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_regs [16];
   logic [15:0] m_busy;
   bundle_t     q[$];

   operand_stage #(.REG_BITS(4), .DATA_WIDTH(32), .R0_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
      .in_writes_rd(in_writes_rd), .in_use_imm(in_use_imm), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_writes_rd(out_writes_rd),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   function automatic bundle_t dut_bundle();
      return {out_op, out_a, out_b, out_rd, out_writes_rd};
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] r);
      if (r == 4'd0) return 32'd0;
      if (wb_en && wb_reg == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic logic m_src_busy(input logic [3:0] r);
      return m_busy[r] && !(wb_en && wb_reg == r);
   endfunction

   function automatic logic m_ready();
      logic hz;
      hz = m_src_busy(in_ra) || (!in_use_imm && m_src_busy(in_rb)) ||
           (in_writes_rd && m_src_busy(in_rd));
      return !rst && !hz && (q.size() == 0 || out_ready);
   endfunction

   task automatic set_idle();
      in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rd = '0;
      in_writes_rd = 1'b0; in_use_imm = 1'b0; in_imm = '0;
      out_ready = 1'b1; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
   endtask

   task automatic drive_in(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rd, input logic wr, input logic ui,
                           input logic [31:0] imm);
      in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
      in_writes_rd = wr; in_use_imm = ui; in_imm = imm;
   endtask

   task automatic drive_wb(input logic [3:0] r, input logic [31:0] d);
      wb_en = 1'b1; wb_reg = r; wb_data = d;
   endtask

   // Advances the reference model by one clock and moves to just after the edge.
   task automatic finish_cycle();
      logic    xfer;
      bundle_t exp;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_busy = '0;
         q.delete();
      end else begin
         xfer = in_valid && m_ready();
         exp  = {in_op, m_read(in_ra), (in_use_imm ? in_imm : m_read(in_rb)), in_rd, in_writes_rd};
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (xfer) q.push_back(exp);
         if (wb_en) begin
            if (wb_reg != 4'd0) m_regs[wb_reg] = wb_data;
            m_busy[wb_reg] = 1'b0;
         end
         if (xfer && in_writes_rd && in_rd != 4'd0) m_busy[in_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wb_cycle(input logic [3:0] r, input logic [31:0] d);
      set_idle();
      drive_wb(r, d);
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (dut_bundle() !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", dut_bundle()); end
      finish_cycle();
      rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
      finish_cycle();
   endtask

   task automatic test_back_to_back();
      wb_cycle(4'd1, 32'd5);
      wb_cycle(4'd2, 32'd7);
      for (int c = 0; c < 3; c++) begin
         set_idle();
         if (c == 0) drive_in(OP_ADD, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, '0);
         if (c == 1) drive_in(OP_SUB, 4'd2, 4'd1, 4'd5, 1'b1, 1'b0, '0);
         @(negedge clk);
         if (c < 2) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b want=1", c, in_ready); end
         end
         if (c == 1) begin
            total++; if (out_a !== 32'd5 || out_b !== 32'd7) begin bad++; $display("FAIL b2b_first a=%0d b=%0d want 5/7", out_a, out_b); end
         end
         if (c == 2) begin
            total++; if (out_a !== 32'd7 || out_b !== 32'd5) begin bad++; $display("FAIL b2b_second a=%0d b=%0d want 7/5", out_a, out_b); end
         end
         if (c > 0) begin
            total++;
            if (out_valid !== 1'b1 || q.size() == 0 || dut_bundle() !== q[0]) begin
               bad++; $display("FAIL b2b_bundle c=%0d got=%h valid=%b", c, dut_bundle(), out_valid);
            end
         end
         finish_cycle();
      end
      wb_cycle(4'd4, 32'h44);
      wb_cycle(4'd5, 32'h55);
   endtask

   task automatic test_raw_bypass();
      set_idle();
      drive_in(OP_ADD, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, '0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_producer_ready got=%b want=1", in_ready); end
      finish_cycle();
      for (int c = 0; c < 3; c++) begin
         set_idle();
         drive_in(OP_OR, 4'd4, 4'd2, 4'd7, 1'b1, 1'b0, '0);
         @(negedge clk);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall c=%0d got=%b want=0", c, in_ready); end
         finish_cycle();
      end
      set_idle();
      drive_in(OP_OR, 4'd4, 4'd2, 4'd7, 1'b1, 1'b0, '0);
      drive_wb(4'd4, 32'h1234);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_release got=%b want=1", in_ready); end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++; if (out_a !== 32'h1234) begin bad++; $display("FAIL raw_bypass_a got=%h want=00001234", out_a); end
      total++;
      if (out_valid !== 1'b1 || q.size() == 0 || dut_bundle() !== q[0]) begin
         bad++; $display("FAIL raw_bundle got=%h valid=%b", dut_bundle(), out_valid);
      end
      finish_cycle();
      wb_cycle(4'd7, 32'h77);
   endtask

   task automatic test_backpressure();
      bundle_t held;
      held = '0;
      set_idle();
      out_ready = 1'b0;
      drive_in(OP_XOR, 4'd1, 4'd2, 4'd8, 1'b0, 1'b0, '0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b want=1", in_ready); end
      finish_cycle();
      for (int c = 0; c < 3; c++) begin
         set_idle();
         out_ready = 1'b0;
         drive_in(OP_AND, 4'd2, 4'd1, 4'd9, 1'b0, 1'b0, '0);
         @(negedge clk);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=0", c, in_ready); end
         if (c == 0) held = dut_bundle();
         total++;
         if (out_valid !== 1'b1 || q.size() == 0 || dut_bundle() !== q[0] || dut_bundle() !== held) begin
            bad++; $display("FAIL bp_hold c=%0d got=%h valid=%b", c, dut_bundle(), out_valid);
         end
         finish_cycle();
      end
      set_idle();
      drive_in(OP_AND, 4'd2, 4'd1, 4'd9, 1'b0, 1'b0, '0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_ready got=%b want=1", in_ready); end
      total++;
      if (q.size() == 0 || dut_bundle() !== q[0] || out_a !== 32'd5 || out_b !== 32'd7) begin
         bad++; $display("FAIL bp_resume_out got=%h", dut_bundle());
      end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_op !== OP_AND || out_a !== 32'd7 || out_b !== 32'd5) begin
         bad++; $display("FAIL bp_second_out got=%h valid=%b", dut_bundle(), out_valid);
      end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
      finish_cycle();
   endtask

   task automatic test_imm_r0();
      set_idle();
      drive_in(OP_ADD, 4'd1, 4'd2, 4'd9, 1'b1, 1'b0, '0);
      @(negedge clk);
      finish_cycle();
      set_idle();
      drive_in(OP_ADD, 4'd1, 4'd9, 4'd10, 1'b0, 1'b1, 32'hFFFF_FFF0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL imm_no_stall got=%b want=1", in_ready); end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++;
      if (out_b !== 32'hFFFF_FFF0 || out_a !== 32'd5 || q.size() == 0 || dut_bundle() !== q[0]) begin
         bad++; $display("FAIL imm_out got a=%h b=%h want 00000005/fffffff0", out_a, out_b);
      end
      finish_cycle();
      wb_cycle(4'd0, 32'hDEAD);
      set_idle();
      drive_in(OP_ADD, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, '0);
      @(negedge clk);
      finish_cycle();
      set_idle();
      drive_in(OP_SUB, 4'd0, 4'd0, 4'd11, 1'b0, 1'b0, '0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL r0_never_busy got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b1 || out_a !== 32'd0) begin bad++; $display("FAIL r0_read_a got=%h want=0", out_a); end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++;
      if (out_a !== 32'd0 || out_b !== 32'd0 || out_op !== OP_SUB) begin
         bad++; $display("FAIL r0_read_ab got a=%h b=%h want 0/0", out_a, out_b);
      end
      finish_cycle();
      wb_cycle(4'd9, 32'h99);
   endtask

   task automatic test_set_clear();
      set_idle();
      drive_in(OP_ADD, 4'd1, 4'd2, 4'd6, 1'b1, 1'b0, '0);
      @(negedge clk);
      finish_cycle();
      set_idle();
      drive_in(OP_SUB, 4'd6, 4'd2, 4'd6, 1'b1, 1'b0, '0);
      drive_wb(4'd6, 32'hABCD);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sc_no_waw got=%b want=1", in_ready); end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++; if (out_a !== 32'hABCD) begin bad++; $display("FAIL sc_bypass got=%h want=0000abcd", out_a); end
      finish_cycle();
      set_idle();
      drive_in(OP_OR, 4'd6, 4'd1, 4'd12, 1'b0, 1'b0, '0);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sc_still_busy got=%b want=0", in_ready); end
      finish_cycle();
      set_idle();
      drive_in(OP_OR, 4'd6, 4'd1, 4'd12, 1'b0, 1'b0, '0);
      drive_wb(4'd6, 32'h5555);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sc_release got=%b want=1", in_ready); end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++;
      if (out_a !== 32'h5555 || out_b !== 32'd5 || q.size() == 0 || dut_bundle() !== q[0]) begin
         bad++; $display("FAIL sc_final got a=%h b=%h want 00005555/00000005", out_a, out_b);
      end
      finish_cycle();
   endtask

   task automatic test_reset_mid();
      set_idle();
      out_ready = 1'b0;
      drive_in(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, '0);
      @(negedge clk);
      finish_cycle();
      set_idle();
      out_ready = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_op !== OP_ADD) begin bad++; $display("FAIL rm_pre got valid=%b op=%h", out_valid, out_op); end
      finish_cycle();
      rst = 1'b1;
      set_idle();
      out_ready = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || dut_bundle() !== '0) begin bad++; $display("FAIL rm_cleared got valid=%b out=%h", out_valid, dut_bundle()); end
      finish_cycle();
      rst = 1'b0;
      set_idle();
      drive_in(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, '0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", in_ready); end
      finish_cycle();
      set_idle();
      @(negedge clk);
      total++;
      if (out_a !== 32'd0 || out_b !== 32'd0 || q.size() == 0 || dut_bundle() !== q[0]) begin
         bad++; $display("FAIL rm_regs_zero got a=%h b=%h want 0/0", out_a, out_b);
      end
      finish_cycle();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_busy = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_raw_bypass();
      test_backpressure();
      test_imm_r0();
      test_set_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
